vector_floating_point_operand_stage: RTL and testbench

//  Registered issue stage directly upstream of the vector FP min/max unit (and sibling vector FP units).

---
 rtl/dragonfang_floating_point_pkg.sv | 25 ++
 rtl/dragonfang_pkg.sv | 15 +
 rtl/vector_floating_point_operand_stage_splat.sv | 28 ++
 rtl/vector_floating_point_operand_stage.sv | 105 ++++++++++
 tb/tb_vector_floating_point_operand_stage.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dragonfang_floating_point_pkg.sv
// Floating-point types and constants shared by the vector FP units.
// SEW encoding plus the single-precision NaN-boxing constants.
package dragonfang_floating_point_pkg;

  localparam int FLEN = 64;

  typedef enum logic {
    SEW_32 = 1'b0,
    SEW_64 = 1'b1
  } sew_t;

  localparam logic [31:0] CANONICAL_NAN_32 = 32'h7FC0_0000;
  localparam logic [31:0] NAN_BOX_32       = 32'hFFFF_FFFF;

  // A single held in a wider register is valid only when NaN-boxed.
  function automatic logic [31:0] unbox_32(
    input logic [FLEN-1:0] value
  );
    if (value[FLEN-1:FLEN-32] == NAN_BOX_32) begin
      return value[31:0];
    end
    return CANONICAL_NAN_32;
  endfunction

endpackage

// File: rtl/dragonfang_pkg.sv
// Core-wide shared types and widths.
// Holds the decoded vector execution control word.
package dragonfang_pkg;

  localparam int VLEN = 128;

  typedef struct packed {
    logic [5:0] funct6;
    logic [2:0] funct3;
    logic [4:0] vd;
    logic       vm;
    logic [2:0] frm;
  } execution_vector_t;

endpackage

// File: rtl/vector_floating_point_operand_stage_splat.sv
// Replicates a scalar FP operand across every element of a vector.
// Singles are NaN-box checked; unboxed values become canonical qNaN.
module vector_scalar_splat
  import dragonfang_floating_point_pkg::*;
#(
  parameter int VLEN = 128,
  parameter int FLEN = 64
) (
  input  logic [FLEN-1:0] fs1,
  input  sew_t            sew,
  output logic [VLEN-1:0] splat
);

  logic [31:0] single;

  assign single = unbox_32(fs1);

  // Pick the element width and replicate across the register.
  always_comb begin
    splat = '0;
    unique case (sew)
      SEW_64:  splat = {(VLEN/FLEN){fs1}};
      SEW_32:  splat = {(VLEN/32){single}};
      default: splat = '0;
    endcase
  end

endmodule

// File: rtl/vector_floating_point_operand_stage.sv
// Issue stage feeding the vector FP units: forms vs1 and
// buffers ops in a 2-entry skid FIFO behind a valid/ready handshake.
module vector_floating_point_operand_stage
  import dragonfang_pkg::*;
  import dragonfang_floating_point_pkg::*;
#(
  parameter int VLEN = dragonfang_pkg::VLEN,
  parameter int FLEN = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  execution_vector_t in_execution_vector,
  input  sew_t              in_sew,
  input  logic              in_scalar_select,
  input  logic [VLEN-1:0]   in_vs2,
  input  logic [VLEN-1:0]   in_vs1,
  input  logic [FLEN-1:0]   in_fs1,
  output logic              out_valid,
  input  logic              out_ready,
  output execution_vector_t execution_vector,
  output logic [VLEN-1:0]   vs2,
  output logic [VLEN-1:0]   vs1,
  output logic              busy
);

  logic [1:0]        count;
  logic              wr_ptr;
  logic              rd_ptr;
  logic              push;
  logic              pop;
  logic [VLEN-1:0]   splat;
  logic [VLEN-1:0]   formed_vs1;

  execution_vector_t ev_mem  [2];
  logic [VLEN-1:0]   vs2_mem [2];
  logic [VLEN-1:0]   vs1_mem [2];

  vector_scalar_splat #(
    .VLEN (VLEN),
    .FLEN (FLEN)
  ) u_splat (
    .fs1   (in_fs1),
    .sew   (in_sew),
    .splat (splat)
  );

  assign formed_vs1 = in_scalar_select ? splat : in_vs1;

  // Readiness comes from registered occupancy only.
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign busy      = (count != 2'd0);

  // Flush overrides any transfer in the same cycle.
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  assign execution_vector = ev_mem[rd_ptr];
  assign vs2              = vs2_mem[rd_ptr];
  assign vs1              = vs1_mem[rd_ptr];

  // Occupancy and pointer bookkeeping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; written only on enqueue, kept across flush.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        ev_mem[i]  <= '0;
        vs2_mem[i] <= '0;
        vs1_mem[i] <= '0;
      end
    end else if (push) begin
      ev_mem[wr_ptr]  <= in_execution_vector;
      vs2_mem[wr_ptr] <= in_vs2;
      vs1_mem[wr_ptr] <= formed_vs1;
    end
  end

endmodule

// File: tb/tb_vector_floating_point_operand_stage.sv
// Bench for the vector FP operand stage.
// A negedge monitor scores outputs against a queue of expected ops.
module tb_vector_floating_point_operand_stage;
  import dragonfang_pkg::*;
  import dragonfang_floating_point_pkg::*;

  localparam int VLEN = 128;
  localparam int FLEN = 64;

  typedef struct packed {
    execution_vector_t ev;
    logic [VLEN-1:0]   vs2;
    logic [VLEN-1:0]   vs1;
  } item_t;

  logic              clock;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  execution_vector_t in_execution_vector;
  sew_t              in_sew;
  logic              in_scalar_select;
  logic [VLEN-1:0]   in_vs2;
  logic [VLEN-1:0]   in_vs1;
  logic [FLEN-1:0]   in_fs1;
  logic              out_valid;
  logic              out_ready;
  execution_vector_t execution_vector;
  logic [VLEN-1:0]   vs2;
  logic [VLEN-1:0]   vs1;
  logic              busy;

  vector_floating_point_operand_stage #(
    .VLEN (VLEN),
    .FLEN (FLEN)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .flush               (flush),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_execution_vector (in_execution_vector),
    .in_sew              (in_sew),
    .in_scalar_select    (in_scalar_select),
    .in_vs2              (in_vs2),
    .in_vs1              (in_vs1),
    .in_fs1              (in_fs1),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .execution_vector    (execution_vector),
    .vs2                 (vs2),
    .vs1                 (vs1),
    .busy                (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int    checks = 0;
  int    errors = 0;
  int    model_count = 0;
  item_t sb [$];
  item_t exp_item;
  item_t got_item;
  logic  pop_now;
  logic  push_now;

  function automatic logic [VLEN-1:0] expect_vs1(
    input sew_t s, input logic sel,
    input logic [VLEN-1:0] v, input logic [FLEN-1:0] f
  );
    logic [31:0] w;
    if (!sel) return v;
    if (s == SEW_64) return {f, f};
    w = (f[63:32] == 32'hFFFF_FFFF) ? f[31:0] : 32'h7FC0_0000;
    return {w, w, w, w};
  endfunction

  function automatic logic [VLEN-1:0] rv();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic execution_vector_t rev();
    logic [31:0] t;
    t = $urandom();
    return t[$bits(execution_vector_t)-1:0];
  endfunction

  // Scoreboard: handshake model, pop-and-compare, push expected.
  always @(negedge clock) begin
    if (reset) begin
      sb.delete();
      model_count = 0;
    end else begin
      checks++;
      if (in_ready !== (model_count != 2)) begin
        errors++;
        $display("FAIL mon_in_ready got %b want %b", in_ready, model_count != 2);
      end
      checks++;
      if (out_valid !== (model_count != 0)) begin
        errors++;
        $display("FAIL mon_out_valid got %b want %b", out_valid, model_count != 0);
      end
      if (flush) begin
        sb.delete();
        model_count = 0;
      end else begin
        pop_now  = out_ready && (model_count != 0);
        push_now = in_valid && (model_count != 2);
        if (pop_now) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL mon_underflow got pop want empty queue");
          end else begin
            exp_item = sb.pop_front();
            got_item = {execution_vector, vs2, vs1};
            if (got_item !== exp_item) begin
              errors++;
              $display("FAIL mon_payload got %h want %h", got_item, exp_item);
            end
          end
          model_count--;
        end
        if (push_now) begin
          sb.push_back({in_execution_vector, in_vs2,
            expect_vs1(in_sew, in_scalar_select, in_vs1, in_fs1)});
          model_count++;
        end
      end
    end
  end

  task automatic offer(
    input execution_vector_t e, input sew_t s, input logic sel,
    input logic [VLEN-1:0] a2, input logic [VLEN-1:0] a1,
    input logic [FLEN-1:0] f
  );
    in_valid            = 1'b1;
    in_execution_vector = e;
    in_sew              = s;
    in_scalar_select    = sel;
    in_vs2              = a2;
    in_vs1              = a1;
    in_fs1              = f;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got v%b r%b b%b want v0 r1 b0",
        out_valid, in_ready, busy);
    end
    checks++;
    if ({execution_vector, vs2, vs1} !== '0) begin
      errors++;
      $display("FAIL reset_payload got %h want 0", {execution_vector, vs2, vs1});
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_vv_latency();
    execution_vector_t e;
    logic [VLEN-1:0] a2, a1;
    e = '0;
    e.funct6 = 6'b000100;
    e.funct3 = 3'b001;
    e.vd = 5'd3;
    a2 = rv();
    a1 = rv();
    @(posedge clock); #1;
    offer(e, SEW_64, 1'b0, a2, a1, 64'h0);
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL vv_no_comb got %b want 0", out_valid);
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || vs2 !== a2 || vs1 !== a1 || execution_vector !== e) begin
      errors++;
      $display("FAIL vv_out got v%b %h %h want v1 %h %h", out_valid, vs2, vs1, a2, a1);
    end
    @(posedge clock); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL vv_drain got %b want 0", out_valid);
    end
  endtask

  task automatic test_vf_64();
    @(posedge clock); #1;
    offer(rev(), SEW_64, 1'b1, rv(), rv(), 64'h4000_0000_0000_0000);
    @(posedge clock); #1;
    in_valid = 1'b0;
    checks++;
    if (vs1 !== 128'h4000_0000_0000_0000_4000_0000_0000_0000) begin
      errors++;
      $display("FAIL vf64_splat got %h want 4000..4000", vs1);
    end
  endtask

  task automatic test_vf_32();
    @(posedge clock); #1;
    offer(rev(), SEW_32, 1'b1, rv(), rv(), 64'hFFFF_FFFF_3F80_0000);
    @(posedge clock); #1;
    offer(rev(), SEW_32, 1'b1, rv(), rv(), 64'h0000_0000_3F80_0000);
    checks++;
    if (vs1 !== {4{32'h3F80_0000}}) begin
      errors++;
      $display("FAIL vf32_boxed got %h want 3f800000 x4", vs1);
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    checks++;
    if (vs1 !== {4{32'h7FC0_0000}}) begin
      errors++;
      $display("FAIL vf32_unboxed got %h want 7fc00000 x4", vs1);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_full();
    logic [VLEN-1:0] a, b, c;
    a = rv();
    b = rv();
    c = rv();
    out_ready = 1'b0;
    @(posedge clock); #1;
    offer(rev(), SEW_64, 1'b0, a, rv(), 64'h0);
    @(posedge clock); #1;
    offer(rev(), SEW_32, 1'b0, b, rv(), 64'h0);
    @(posedge clock); #1;
    offer(rev(), SEW_64, 1'b1, c, rv(), 64'h1234_5678_9ABC_DEF0);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || vs2 !== a) begin
      errors++;
      $display("FAIL full_state got r%b v%b %h want r0 v1 %h", in_ready, out_valid, vs2, a);
    end
    @(posedge clock); #1;
    checks++;
    if (in_ready !== 1'b0 || vs2 !== a) begin
      errors++;
      $display("FAIL full_hold got r%b %h want r0 %h", in_ready, vs2, a);
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (vs2 !== b || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_b got r%b %h want r1 %h", in_ready, vs2, b);
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    checks++;
    if (vs2 !== c || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL full_c got v%b %h want v1 %h", out_valid, vs2, c);
    end
    @(posedge clock); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_drain got %b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [VLEN-1:0] v [16];
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      v[i] = rv();
    end
    for (int i = 0; i < 16; i++) begin
      @(posedge clock); #1;
      if (i > 0) begin
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b1
            || vs2 !== v[i-1]) begin
          errors++;
          $display("FAIL b2b_%0d got v%b r%b %h want v1 r1 %h",
            i, out_valid, in_ready, vs2, v[i-1]);
        end
      end
      offer(rev(), (i % 2 == 0) ? SEW_64 : SEW_32, i[2], v[i], rv(),
        {$urandom(), $urandom()});
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    checks++;
    if (vs2 !== v[15] || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_last got v%b %h want v1 %h", out_valid, vs2, v[15]);
    end
    @(posedge clock); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain got %b want 0", out_valid);
    end
  endtask

  task automatic test_flush_reset();
    logic [VLEN-1:0] z;
    z = rv();
    out_ready = 1'b0;
    @(posedge clock); #1;
    offer(rev(), SEW_64, 1'b0, rv(), rv(), 64'h0);
    @(posedge clock); #1;
    offer(rev(), SEW_64, 1'b0, rv(), rv(), 64'h0);
    @(posedge clock); #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL pre_flush_full got %b want 0", in_ready);
    end
    flush = 1'b1;
    out_ready = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_state got v%b b%b r%b want v0 b0 r1",
        out_valid, busy, in_ready);
    end
    @(posedge clock); #1;
    offer(rev(), SEW_32, 1'b1, rv(), rv(), 64'hFFFF_FFFF_0000_0001);
    @(posedge clock); #1;
    offer(rev(), SEW_64, 1'b0, rv(), rv(), 64'h0);
    @(posedge clock); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset_full got v%b r%b want v1 r0", out_valid, in_ready);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1
        || {execution_vector, vs2, vs1} !== '0) begin
      errors++;
      $display("FAIL async_reset got v%b b%b r%b %h want v0 b0 r1 0",
        out_valid, busy, in_ready, vs2);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    offer(rev(), SEW_64, 1'b0, z, rv(), 64'h0);
    out_ready = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || vs2 !== z) begin
      errors++;
      $display("FAIL recover got v%b %h want v1 %h", out_valid, vs2, z);
    end
    @(posedge clock); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_execution_vector = '0;
    in_sew = SEW_64;
    in_scalar_select = 1'b0;
    in_vs2 = '0;
    in_vs1 = '0;
    in_fs1 = '0;
    test_reset();
    test_vv_latency();
    test_vf_64();
    test_vf_32();
    test_full();
    test_back_to_back();
    test_flush_reset();
    @(negedge clock);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
